pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 123 ++++++++++++
 tb/tb_pipe_adder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Slice-pipelined adder/subtractor: NSTAGE = WIDTH/SLICE register stages, one slice per stage.
// Optional signed-overflow output ovf is built only when PIPE_ADDER_OVF_EN is defined.
module pipe_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSTAGE = WIDTH / SLICE;

    // Handshake: a transfer happens on a side when valid && ready at a rising edge.
    // The whole pipeline moves as one (adv); in_ready is adv and never looks at in_valid.
    logic adv;

    // Per-stage registers. pa_q/pb_q hold the not-yet-added upper operand bits,
    // shifted down so the next slice to add always sits at bits [SLICE-1:0].
    logic             v_q   [NSTAGE];
    logic             c_q   [NSTAGE];
    logic             sub_q [NSTAGE];
    logic [WIDTH-1:0] pa_q  [NSTAGE];
    logic [WIDTH-1:0] pb_q  [NSTAGE];
    logic [WIDTH-1:0] sum_q [NSTAGE];

    // Inputs seen by each stage's slice adder.
    logic [WIDTH-1:0] op_a    [NSTAGE];
    logic [WIDTH-1:0] op_b    [NSTAGE];
    logic             st_sub  [NSTAGE];
    logic             st_cin  [NSTAGE];
    logic             st_v    [NSTAGE];
    logic [WIDTH-1:0] st_sum  [NSTAGE];
    logic [SLICE-1:0] b_slice [NSTAGE];
    logic [SLICE:0]   res     [NSTAGE];

    assign adv       = !v_q[NSTAGE-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[NSTAGE-1];
    assign sum       = sum_q[NSTAGE-1];
    assign carry     = c_q[NSTAGE-1];

    generate
        for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
            if (k == 0) begin : g_head
                // Subtract is a + ~b + ~cin, so the borrow-in is inverted up front.
                assign op_a[k]   = a;
                assign op_b[k]   = b;
                assign st_sub[k] = sub;
                assign st_cin[k] = sub ? ~cin : cin;
                assign st_v[k]   = in_valid;
                assign st_sum[k] = '0;
            end else begin : g_body
                assign op_a[k]   = pa_q[k-1];
                assign op_b[k]   = pb_q[k-1];
                assign st_sub[k] = sub_q[k-1];
                assign st_cin[k] = c_q[k-1];
                assign st_v[k]   = v_q[k-1];
                assign st_sum[k] = sum_q[k-1];
            end

            assign b_slice[k] = st_sub[k] ? ~op_b[k][SLICE-1:0] : op_b[k][SLICE-1:0];
            assign res[k]     = {1'b0, op_a[k][SLICE-1:0]} + {1'b0, b_slice[k]}
                              + {{SLICE{1'b0}}, st_cin[k]};
        end
    endgenerate

    // Finished slices enter at the top of the sum word and shift down one slice per
    // stage, so after the last stage every slice sits in its final bit position.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                v_q[k]   <= 1'b0;
                c_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
                pa_q[k]  <= '0;
                pb_q[k]  <= '0;
                sum_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < NSTAGE; k++) begin
                v_q[k]   <= st_v[k];
                c_q[k]   <= res[k][SLICE];
                sub_q[k] <= st_sub[k];
                pa_q[k]  <= op_a[k] >> SLICE;
                pb_q[k]  <= op_b[k] >> SLICE;
                sum_q[k] <= (st_sum[k] >> SLICE)
                          | (WIDTH'(res[k][SLICE-1:0]) << (WIDTH - SLICE));
            end
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    // The sign bits of a, effective b and the result all live in the last slice,
    // so overflow is resolved in the final stage and lands alongside sum.
    logic ovf_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= (op_a[NSTAGE-1][SLICE-1] == b_slice[NSTAGE-1][SLICE-1])
                  && (res[NSTAGE-1][SLICE-1] != op_a[NSTAGE-1][SLICE-1]);
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: a transaction-level reference model (whole-word
// arithmetic plus a slot queue for timing) checked with immediate assertions.
module tb_pipe_adder;

    localparam int W = 32;
    localparam int S = 8;
    localparam int N = W / S;
    localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (W - 1));

    // Clock / reset
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Main DUT (32/8)
    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, carry;
    logic [W-1:0] a, b, sum;
`ifdef PIPE_ADDER_OVF_EN
    logic         ovf;
`endif

    pipe_adder #(.WIDTH(W), .SLICE(S)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .carry(carry)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    // Single-stage DUT (16/16)
    logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, carry1;
    logic [15:0] a1, b1, sum1;
`ifdef PIPE_ADDER_OVF_EN
    logic        ovf1;
`endif

    pipe_adder #(.WIDTH(16), .SLICE(16)) dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sum(sum1), .carry(carry1)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

    // Scoreboard / reference model
    typedef struct {
        bit           v;
        logic [W-1:0] s;
        bit           c;
        bit           o;
    } slot_t;

    slot_t pipe [N];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    n_out = 0;

    function automatic slot_t ref_op(logic [W-1:0] ra, logic [W-1:0] rb, bit rc, bit rs);
        slot_t  r;
        logic [W:0] tot;
        longint sa, sb, t;
        sa = $signed(ra);
        sb = $signed(rb);
        r.v = 1'b1;
        if (!rs) begin
            tot = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
            r.s = tot[W-1:0];
            r.c = tot[W];
            t   = sa + sb + longint'(rc);
        end else begin
            r.s = ra - rb - W'(rc);
            r.c = ({1'b0, ra} >= ({1'b0, rb} + (W+1)'(rc)));
            t   = sa - sb - longint'(rc);
        end
        r.o = (t > SMAX) || (t < SMIN);
        return r;
    endfunction

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic op(logic [W-1:0] x, logic [W-1:0] y, bit c, bit s);
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = c;
        sub = s;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // One clock: check outputs against the model, advance the model with the inputs
    // that the next rising edge will sample, then wait for the falling edge.
    task automatic step();
        bit adv_m;
        #1;
        check("out_valid", W'(out_valid), W'(pipe[N-1].v));
        check("in_ready", W'(in_ready), W'(!pipe[N-1].v || out_ready));
        if (pipe[N-1].v) begin
            check("sum", sum, pipe[N-1].s);
            check("carry", W'(carry), W'(pipe[N-1].c));
`ifdef PIPE_ADDER_OVF_EN
            check("ovf", W'(ovf), W'(pipe[N-1].o));
`endif
        end
        adv_m = !pipe[N-1].v || out_ready;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                pipe[i].v = 1'b0;
                pipe[i].s = '0;
                pipe[i].c = 1'b0;
                pipe[i].o = 1'b0;
            end
        end else if (adv_m) begin
            if (pipe[N-1].v && out_ready) n_out++;
            for (int i = N - 1; i > 0; i--) pipe[i] = pipe[i-1];
            if (in_valid) pipe[0] = ref_op(a, b, cin, sub);
            else pipe[0].v = 1'b0;
        end
        @(negedge clock);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit pend;
        bit acc;
        int issued;
        int base;

        for (int i = 0; i < N; i++) begin
            pipe[i].v = 1'b0;
            pipe[i].s = '0;
            pipe[i].c = 1'b0;
            pipe[i].o = 1'b0;
        end

        // Reset with junk transfers presented (must be ignored)
        reset = 1'b1;
        out_ready = 1'b1;
        op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
        in_valid1 = 1'b1; a1 = 16'hAAAA; b1 = 16'h5555; cin1 = 1'b0; sub1 = 1'b0;
        out_ready1 = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_sum", sum, '0);
        check("rst_carry", W'(carry), '0);
`ifdef PIPE_ADDER_OVF_EN
        check("rst_ovf", W'(ovf), '0);
`endif
        check("rst1_out_valid", W'(out_valid1), '0);
        in_valid1 = 1'b0;

        // Leave reset: in_ready high, nothing emerges
        reset = 1'b0;
        idle();
        repeat (N + 1) step();

        // Directed: full carry ripple, subtract with borrow, signed overflow
        op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); step();
        op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1); step();
        op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); step();
        idle(); step();
        check("ripple_valid", W'(out_valid), 32'd1);
        check("ripple_sum", sum, 32'h0000_0000);
        check("ripple_carry", W'(carry), 32'd1);
        step();
        check("sub_sum", sum, 32'hFFFF_FFFE);
        check("sub_carry", W'(carry), 32'd0);
`ifdef PIPE_ADDER_OVF_EN
        check("sub_ovf", W'(ovf), 32'd0);
`endif
        step();
        check("ovf_sum", sum, 32'h8000_0000);
        check("ovf_carry", W'(carry), 32'd0);
`ifdef PIPE_ADDER_OVF_EN
        check("ovf_ovf", W'(ovf), 32'd1);
`endif
        repeat (N) step();

        // 8 back-to-back ops alternating sub, downstream stalls cycles 6-8
        issued = 0;
        base = n_out;
        pend = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            out_ready = !(cyc >= 6 && cyc <= 8);
            if (!pend && issued < 8) begin
                op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), issued[0]);
                pend = 1'b1;
            end
            acc = pend && (!pipe[N-1].v || out_ready);
            step();
            if (acc) begin
                pend = 1'b0;
                issued++;
                idle();
            end
        end
        check("b2b_issued", W'(issued), 32'd8);
        check("b2b_outputs", W'(n_out - base), 32'd8);

        // Reset in the middle of three operations discards them all
        out_ready = 1'b1;
        op(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0); step();
        op(32'h0000_0033, 32'h0000_0044, 1'b1, 1'b1); step();
        op(32'h0000_0055, 32'h0000_0066, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_valid", W'(out_valid), '0);
        check("midrst_sum", sum, '0);
        check("midrst_carry", W'(carry), '0);
        idle();
        repeat (N + 1) step();
        op(32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0); step();
        idle();
        repeat (N - 1) step();
        check("postrst_valid", W'(out_valid), 32'd1);
        check("postrst_sum", sum, 32'h0001_0001);
        check("postrst_carry", W'(carry), 32'd0);
        step();

        // Randomized traffic with random backpressure; operands held until accepted
        pend = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pend && $urandom_range(0, 4) != 0) begin
                op(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                pend = 1'b1;
            end
            acc = pend && (!pipe[N-1].v || out_ready);
            step();
            if (acc) begin
                pend = 1'b0;
                idle();
            end
        end
        idle();
        out_ready = 1'b1;
        repeat (N + 2) step();

        // Single-stage build: one registered adder, latency 1
        in_valid1 = 1'b1; a1 = 16'h1234; b1 = 16'h0001; cin1 = 1'b1; sub1 = 1'b0;
        step();
        check("n1_valid", W'(out_valid1), 32'd1);
        check("n1_sum", W'(sum1), 32'h0000_1236);
        check("n1_carry", W'(carry1), 32'd0);
        a1 = 16'h0000; b1 = 16'h0001; cin1 = 1'b0; sub1 = 1'b1;
        step();
        check("n1_sub_sum", W'(sum1), 32'h0000_FFFF);
        check("n1_sub_carry", W'(carry1), 32'd0);
`ifdef PIPE_ADDER_OVF_EN
        check("n1_sub_ovf", W'(ovf1), 32'd0);
`endif
        in_valid1 = 1'b0;
        step();
        check("n1_idle_valid", W'(out_valid1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
